// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one registered grant (one-hot + index) held until release, one turnaround cycle between owners.
// Optional forced release after TIMEOUT grant cycles when the GRANT_TIMEOUT_EN macro is defined.
module rr_grant_arbiter #(
    parameter int REQ_WIDTH = 8,
    parameter int IDX_WIDTH = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 done,
    output logic [REQ_WIDTH-1:0] grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_WIDTH-1:0] ptr_reg, ptr_next;
    logic [IDX_WIDTH-1:0] idx_reg, idx_next;
    logic [REQ_WIDTH-1:0] grant_reg, grant_next;
    logic                 valid_reg, valid_next;
    logic                 tpulse_reg, tpulse_next;

    logic [REQ_WIDTH-1:0] req_hi;
    logic [REQ_WIDTH-1:0] win_onehot;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH-1:0] ptr_adv;
    logic                 owner_req;
    logic                 arb_ok;
    logic                 release_evt;

    if ((2 ** IDX_WIDTH) < REQ_WIDTH || REQ_WIDTH < 2 || TIMEOUT < 2) begin : g_param_check
        $error("rr_grant_arbiter: illegal REQ_WIDTH/IDX_WIDTH/TIMEOUT combination");
    end

    // Requests at or above the pointer win first; otherwise fall back to the lowest request (wrap).
    generate
        for (genvar gi = 0; gi < REQ_WIDTH; gi++) begin : g_bit
            localparam logic [IDX_WIDTH-1:0] BIT_IDX = IDX_WIDTH'(gi);
            assign req_hi[gi]     = req[gi] & (BIT_IDX >= ptr_reg);
            assign win_onehot[gi] = (win_idx == BIT_IDX);
        end
    endgenerate

    function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [REQ_WIDTH-1:0] v);
        lowest_set = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_WIDTH'(i);
        end
    endfunction

    assign win_idx   = (|req_hi) ? lowest_set(req_hi) : lowest_set(req);
    assign owner_req = |(req & grant_reg);
    assign arb_ok    = en & (|req);
    assign ptr_adv   = (idx_reg == IDX_WIDTH'(REQ_WIDTH - 1)) ? '0 : idx_reg + IDX_WIDTH'(1);
    assign release_evt = done | ~owner_req;

`ifdef GRANT_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT + 1);
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              expire;
    assign expire = (hold_reg == HOLD_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        idx_next    = idx_reg;
        grant_next  = grant_reg;
        valid_next  = valid_reg;
        tpulse_next = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        hold_next   = hold_reg;
`endif
        case (state_reg)
            // The turnaround cycle itself is the only grant-free cycle; its exit edge arbitrates like IDLE.
            IDLE, TURN: begin
                state_next = IDLE;
                if (arb_ok) begin
                    state_next = GRANT;
                    grant_next = win_onehot;
                    idx_next   = win_idx;
                    valid_next = 1'b1;
`ifdef GRANT_TIMEOUT_EN
                    hold_next  = '0;
`endif
                end
            end
            GRANT: begin
`ifdef GRANT_TIMEOUT_EN
                hold_next = hold_reg + HOLD_W'(1);
                if (release_evt || expire) begin
                    tpulse_next = ~release_evt;
`else
                if (release_evt) begin
`endif
                    state_next = TURN;
                    ptr_next   = ptr_adv;
                    grant_next = '0;
                    idx_next   = '0;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                idx_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            idx_reg    <= '0;
            grant_reg  <= '0;
            valid_reg  <= 1'b0;
            tpulse_reg <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            hold_reg   <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            idx_reg    <= idx_next;
            grant_reg  <= grant_next;
            valid_reg  <= valid_next;
            tpulse_reg <= tpulse_next;
`ifdef GRANT_TIMEOUT_EN
            hold_reg   <= hold_next;
`endif
        end
    end

    assign grant         = grant_reg;
    assign grant_idx     = idx_reg;
    assign grant_valid   = valid_reg;
    assign timeout_pulse = tpulse_reg;

endmodule
